// File: rtl/mdc_ctrl.sv
// mdc_ctrl: front-end sequencer for the subtractive GCD datapath (mdc_s).
//
// Accepts an operand pair over a valid/ready handshake, loads it into the
// datapath with a one-cycle strobe, waits for done (bounded by a cycle
// budget), then presents the result downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid/in_ready         operand handshake; in_a, in_b operands
//   out_valid/out_ready       result handshake
//   out_res                   GCD result (0 on timeout)
//   out_cycles                WAIT cycles spent, including the done cycle
//   out_timeout               result aborted by the cycle budget
//   busy                      high in LOAD or WAIT
//   dp_ld, dp_a, dp_b         load strobe and operands to the datapath
//   dp_res, dp_done           result and done from the datapath
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for an operand pair
// LOAD  | dp_ld high for one cycle; datapath done is stale, ignored
// WAIT  | counting cycles until dp_done or the cycle budget runs out
// OUT   | result presented, held until out_ready

module mdc_ctrl #(
    parameter int W          = 32,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_res,
    output logic [CW-1:0] out_cycles,
    output logic          out_timeout,
    output logic          busy,
    output logic          dp_ld,
    output logic [W-1:0]  dp_a,
    output logic [W-1:0]  dp_b,
    input  logic [W-1:0]  dp_res,
    input  logic          dp_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CYCLES);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Cycle number of the current WAIT cycle (1-based).
    assign cnt_nxt = cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_res     <= '0;
            out_cycles  <= '0;
            out_timeout <= 1'b0;
            busy        <= 1'b0;
            dp_ld       <= 1'b0;
            dp_a        <= '0;
            dp_b        <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dp_a     <= in_a;
                        dp_b     <= in_b;
                        cnt      <= '0;
                        dp_ld    <= 1'b1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    dp_ld <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    // done is checked first so it wins over a coincident timeout
                    if (dp_done) begin
                        out_res     <= dp_res;
                        out_cycles  <= cnt_nxt;
                        out_timeout <= 1'b0;
                        out_valid   <= 1'b1;
                        busy        <= 1'b0;
                        state       <= OUT;
                    end else if (cnt_nxt == CNT_MAX) begin
                        out_res     <= '0;
                        out_cycles  <= cnt_nxt;
                        out_timeout <= 1'b1;
                        out_valid   <= 1'b1;
                        busy        <= 1'b0;
                        state       <= OUT;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    dp_ld     <= 1'b0;
                end
            endcase
        end
    end

endmodule
